inst_queue: RTL and testbench
=============================

# inst_queue

Dual-issue instruction queue between fetch and decode/dispatch. It buffers up to two fetched instructions per cycle, together with their PC and branch-prediction metadata, in program order. Each cycle it presents the two oldest entries as the inst1/inst2 slots consumed by decode, and decode retires 0, 1 or 2 of them. It decouples fetch stalls from rename/dispatch stalls and is emptied on pipeline flush.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, ≥4
- META_W, 8, opaque per-instruction metadata (br_taken, BHT index, fetch exception bits); carried unmodified

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  empties the queue (exception/eret/mispredict redirect)
- fs_inst1_valid  in  1  fetch slot 1 valid
- fs_inst1_pc  in  32  slot 1 PC
- fs_inst1_word  in  32  slot 1 instruction word
- fs_inst1_meta  in  META_W  slot 1 metadata
- fs_inst2_valid, fs_inst2_pc, fs_inst2_word, fs_inst2_meta  in  1/32/32/META_W  fetch slot 2, same meaning
- iq_ready  out  1  queue can accept two instructions this cycle
- ds_inst1_valid  out  1  oldest entry present
- ds_inst1_pc, ds_inst1_word, ds_inst1_meta  out  32/32/META_W  oldest entry
- ds_inst2_valid  out  1  second-oldest entry present
- ds_inst2_pc, ds_inst2_word, ds_inst2_meta  out  32/32/META_W  second-oldest entry
- ds_deq_num  in  2  entries consumed by decode this cycle (0, 1 or 2)
- iq_count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Circular buffer; head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is held in a separate counter so that full and empty are unambiguous.
- Enqueue happens only when iq_ready=1. Valid fetch slots are compacted in order:
  - both valid → slot 1 at tail, slot 2 at tail+1, tail += 2
  - only slot 1 valid, or only slot 2 valid → that slot at tail, tail += 1
  - neither valid → no change
- Fetch inputs presented while iq_ready=0 are ignored; fetch must hold and retry.
- iq_ready = (DEPTH − iq_count) ≥ 2, computed from registered count only. Same-cycle dequeue does not raise ready.
- Dequeue: head += ds_deq_num and count −= ds_deq_num.
  - ds_deq_num=3 is illegal.
  - ds_deq_num greater than the number of valid outputs is illegal and is flagged by an assertion.
- Output validity: ds_inst1_valid = count≥1; ds_inst2_valid = count≥2. Outputs are read combinationally from the storage entries at head and head+1.
- When ds_instN_valid=0, the corresponding pc, word and meta outputs are 0.
- Simultaneous enqueue and dequeue: count_next = count + enq_num − ds_deq_num.
- flush has priority over enqueue and dequeue. It sets head=tail=0 and count=0 next cycle; fetch inputs and ds_deq_num in the flush cycle are discarded.
- Storage contents are not cleared by flush or reset; only the pointers and count are reset.

## Timing
- Reset values: iq_ready=1, iq_count=0, ds_inst1_valid=0, ds_inst2_valid=0, all payload outputs 0.
- Reset asserted mid-operation clears pointers and count immediately (asynchronously). Any in-flight enqueue in that cycle is lost.
- Enqueue-to-output latency is 1 cycle: an instruction written at edge N is visible on ds_inst* after edge N.
- Dequeue takes effect at the clock edge. The new head entries are visible in the following cycle.
- Full boundary: at count=DEPTH−1, iq_ready=0, even when only one fetch slot is valid.
- Wrap-around: an enqueue of two at tail=DEPTH−1 writes entries DEPTH−1 and 0. An output pair at head=DEPTH−1 reads entries DEPTH−1 and 0.
- First cycle after flush: outputs are invalid and iq_ready=1.

## Configuration
- IQ_BYPASS_EN defined:
  - When count=0 and not flushing, valid fetch slots (compacted as above) drive ds_inst1/ds_inst2 combinationally in the same cycle.
  - Entries decode consumes via ds_deq_num in that cycle are not written.
  - Remaining entries are written at tail, and count reflects only the written entries.
  - Enqueue-to-output latency is 0 when empty.
- IQ_BYPASS_EN undefined: no fetch→decode combinational path; latency is always 1 cycle.

## Test plan
- Reset, then enqueue PC 0xBFC00000/0xBFC00004 with deq_num=0 → next cycle ds_inst1_pc=0xBFC00000, ds_inst2_pc=0xBFC00004, iq_count=2.
- Enqueue only fs_inst2 (PC 0x100) into an empty queue → ds_inst1_pc=0x100, ds_inst1_valid=1, ds_inst2_valid=0, iq_count=1.
- Fill to 15 entries (DEPTH=16) → iq_ready=0. Offer a pair → ignored, count stays 15. Then deq_num=2 → count=13 and iq_ready=1 next cycle.
- Steady state: enqueue 2 and dequeue 2 for 40 cycles across wrap-around → order preserved, iq_count constant, head/tail wrap from 15 to 0 correctly.
- Count=6 with flush, enqueue pair and deq_num=1 in the same cycle → next cycle iq_count=0, both outputs invalid, flushed pair absent.
- With IQ_BYPASS_EN, empty queue, enqueue PC 0x200/0x204 with deq_num=1 in the same cycle → ds_inst1_pc=0x200 same cycle; next cycle ds_inst1_pc=0x204, iq_count=1.

Source files
------------

// File: rtl/inst_queue.sv
// inst_queue: dual-issue instruction queue between fetch and decode.
// Circular buffer of DEPTH entries holding {pc, word, meta} in program order.
// Up to two fetch slots are compacted and written per cycle; decode retires 0..2 per cycle.
// Optional feature macro: IQ_BYPASS_EN (fetch -> decode combinational path when empty).
module inst_queue #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned META_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       fs_inst1_valid,
    input  logic [31:0]                fs_inst1_pc,
    input  logic [31:0]                fs_inst1_word,
    input  logic [META_W-1:0]          fs_inst1_meta,
    input  logic                       fs_inst2_valid,
    input  logic [31:0]                fs_inst2_pc,
    input  logic [31:0]                fs_inst2_word,
    input  logic [META_W-1:0]          fs_inst2_meta,
    output logic                       iq_ready,
    output logic                       ds_inst1_valid,
    output logic [31:0]                ds_inst1_pc,
    output logic [31:0]                ds_inst1_word,
    output logic [META_W-1:0]          ds_inst1_meta,
    output logic                       ds_inst2_valid,
    output logic [31:0]                ds_inst2_pc,
    output logic [31:0]                ds_inst2_word,
    output logic [META_W-1:0]          ds_inst2_meta,
    input  logic [1:0]                 ds_deq_num,
    output logic [$clog2(DEPTH):0]     iq_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 64 + META_W;
    localparam logic [AW-1:0] PtrOne = AW'(1);
    localparam logic [CW-1:0] ReadyMax = CW'(DEPTH - 2);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [EW-1:0] slot1, slot2, cmp0, cmp1, rd0, rd1, out0, out1, wr0, wr1;
    logic [1:0]    enq_num, acc_num, wr_num, avail;
    logic          byp;

    assign slot1 = {fs_inst1_pc, fs_inst1_word, fs_inst1_meta};
    assign slot2 = {fs_inst2_pc, fs_inst2_word, fs_inst2_meta};

    // Ready depends only on the registered count; same-cycle dequeue does not help.
    assign iq_ready = (count_q <= ReadyMax);
    assign iq_count = count_q;

    assign rd0 = mem_q[head_q];
    assign rd1 = mem_q[head_q + PtrOne];

`ifdef IQ_BYPASS_EN
    assign byp = (count_q == '0) && !flush;
`else
    assign byp = 1'b0;
`endif

    // Compact valid fetch slots in program order; accept only when ready and not flushing.
    always_comb begin
        enq_num = 2'd0;
        cmp0    = '0;
        cmp1    = '0;
        if (fs_inst1_valid && fs_inst2_valid) begin
            cmp0    = slot1;
            cmp1    = slot2;
            enq_num = 2'd2;
        end else if (fs_inst1_valid) begin
            cmp0    = slot1;
            enq_num = 2'd1;
        end else if (fs_inst2_valid) begin
            cmp0    = slot2;
            enq_num = 2'd1;
        end
        acc_num = (iq_ready && !flush) ? enq_num : 2'd0;
    end

    // Select output source (storage or bypassed fetch slots) and zero invalid payloads.
    always_comb begin
        if (byp) begin
            avail = acc_num;
            out0  = cmp0;
            out1  = cmp1;
        end else begin
            avail = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
            out0  = rd0;
            out1  = rd1;
        end
        ds_inst1_valid = (avail >= 2'd1);
        ds_inst2_valid = (avail == 2'd2);
        if (!ds_inst1_valid) out0 = '0;
        if (!ds_inst2_valid) out1 = '0;
        {ds_inst1_pc, ds_inst1_word, ds_inst1_meta} = out0;
        {ds_inst2_pc, ds_inst2_word, ds_inst2_meta} = out1;
    end

    // Entries consumed straight from fetch in bypass mode are never written.
    always_comb begin
        wr_num = acc_num;
        wr0    = cmp0;
        wr1    = cmp1;
        if (byp) begin
            wr_num = (ds_deq_num >= acc_num) ? 2'd0 : acc_num - ds_deq_num;
            if (ds_deq_num == 2'd1) wr0 = cmp1;
        end
    end

    // Pointer and occupancy next state; flush wins over everything.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (byp) begin
            tail_d  = tail_q + AW'(wr_num);
            count_d = count_q + CW'(wr_num);
        end else begin
            tail_d  = tail_q + AW'(wr_num);
            head_d  = head_q + AW'(ds_deq_num);
            count_d = count_q + CW'(wr_num) - CW'(ds_deq_num);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately not reset; pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (wr_num != 2'd0) mem_q[tail_q] <= wr0;
        if (wr_num == 2'd2) mem_q[tail_q + PtrOne] <= wr1;
    end

    // Decode must never retire more entries than are presented.
    property p_deq_legal;
        @(posedge clk) disable iff (reset) !flush |-> (ds_deq_num <= avail);
    endproperty
    a_deq_legal: assert property (p_deq_legal)
        else $error("inst_queue: ds_deq_num exceeds valid outputs");

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue (DEPTH=16, META_W=8).
module tb_inst_queue;

    localparam int DEPTH = 16;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic [7:0]  meta;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        fs_inst1_valid = 1'b0, fs_inst2_valid = 1'b0;
    logic [31:0] fs_inst1_pc = '0, fs_inst1_word = '0, fs_inst2_pc = '0, fs_inst2_word = '0;
    logic [7:0]  fs_inst1_meta = '0, fs_inst2_meta = '0;
    logic        iq_ready, ds_inst1_valid, ds_inst2_valid;
    logic [31:0] ds_inst1_pc, ds_inst1_word, ds_inst2_pc, ds_inst2_word;
    logic [7:0]  ds_inst1_meta, ds_inst2_meta;
    logic [1:0]  ds_deq_num = 2'd0;
    logic [4:0]  iq_count;

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t exp_q[$];

    inst_queue #(.DEPTH(DEPTH), .META_W(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .fs_inst1_valid(fs_inst1_valid), .fs_inst1_pc(fs_inst1_pc),
        .fs_inst1_word(fs_inst1_word), .fs_inst1_meta(fs_inst1_meta),
        .fs_inst2_valid(fs_inst2_valid), .fs_inst2_pc(fs_inst2_pc),
        .fs_inst2_word(fs_inst2_word), .fs_inst2_meta(fs_inst2_meta),
        .iq_ready(iq_ready),
        .ds_inst1_valid(ds_inst1_valid), .ds_inst1_pc(ds_inst1_pc),
        .ds_inst1_word(ds_inst1_word), .ds_inst1_meta(ds_inst1_meta),
        .ds_inst2_valid(ds_inst2_valid), .ds_inst2_pc(ds_inst2_pc),
        .ds_inst2_word(ds_inst2_word), .ds_inst2_meta(ds_inst2_meta),
        .ds_deq_num(ds_deq_num), .iq_count(iq_count)
    );

    always #5 clk = ~clk;

    function automatic ent_t mk(input logic [31:0] pc);
        ent_t e;
        e.pc   = pc;
        e.word = ~pc ^ 32'h1357_9BDF;
        e.meta = pc[9:2] ^ 8'h5A;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare all registered-state outputs against the scoreboard.
    task automatic check_outputs();
        ent_t z, e1, e2;
        int   sz;
        z  = '{pc: '0, word: '0, meta: '0};
        sz = exp_q.size();
        e1 = (sz >= 1) ? exp_q[0] : z;
        e2 = (sz >= 2) ? exp_q[1] : z;
        check("count", 64'(iq_count), 64'(sz));
        check("ready", 64'(iq_ready), 64'(sz <= DEPTH - 2));
        check("v1", 64'(ds_inst1_valid), 64'(sz >= 1));
        check("v2", 64'(ds_inst2_valid), 64'(sz >= 2));
        check("pc1", 64'(ds_inst1_pc), 64'(e1.pc));
        check("word1", 64'(ds_inst1_word), 64'(e1.word));
        check("meta1", 64'(ds_inst1_meta), 64'(e1.meta));
        check("pc2", 64'(ds_inst2_pc), 64'(e2.pc));
        check("word2", 64'(ds_inst2_word), 64'(e2.word));
        check("meta2", 64'(ds_inst2_meta), 64'(e2.meta));
    endtask

    task automatic drive(input bit v1, input logic [31:0] p1, input bit v2,
                         input logic [31:0] p2, input int deq, input bit fl);
        ent_t a, b;
        a = mk(p1);
        b = mk(p2);
        fs_inst1_valid = v1; fs_inst1_pc = a.pc; fs_inst1_word = a.word; fs_inst1_meta = a.meta;
        fs_inst2_valid = v2; fs_inst2_pc = b.pc; fs_inst2_word = b.word; fs_inst2_meta = b.meta;
        ds_deq_num = 2'(deq);
        flush = fl;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0);
    endtask

    // One cycle: check state, drive stimulus, update scoreboard at the edge.
    task automatic cycle(input bit v1, input logic [31:0] p1, input bit v2,
                         input logic [31:0] p2, input int deq, input bit fl);
        bit rdy;
        check_outputs();
        rdy = (DEPTH - exp_q.size()) >= 2;
        drive(v1, p1, v2, p2, deq, fl);
        if (fl) begin
            exp_q.delete();
        end else begin
            for (int i = 0; i < deq; i++) void'(exp_q.pop_front());
            if (rdy && v1) exp_q.push_back(mk(p1));
            if (rdy && v2) exp_q.push_back(mk(p2));
        end
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && exp_q.size() > 0; i++)
            cycle(1'b0, 32'h0, 1'b0, 32'h0, (exp_q.size() >= 2) ? 2 : 1, 1'b0);
    endtask

    initial begin
        logic [31:0] pc;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state, then a basic pair.
        cycle(1'b1, 32'hBFC0_0000, 1'b1, 32'hBFC0_0004, 0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 2, 1'b0);

        // Only slot 2 valid compacts into the head slot.
        cycle(1'b0, 32'h0, 1'b1, 32'h0000_0100, 0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1, 1'b0);

        // Fill to DEPTH-1, offer a pair while not ready, then dequeue two.
        pc = 32'h0000_1000;
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, pc, 1'b1, pc + 4, 0, 1'b0);
            pc += 8;
        end
        cycle(1'b1, pc, 1'b0, 32'h0, 0, 1'b0);
        cycle(1'b1, 32'hDEAD_0000, 1'b1, 32'hDEAD_0004, 0, 1'b0);
        cycle(1'b1, 32'hDEAD_0010, 1'b0, 32'h0, 0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 2, 1'b0);
        check("count13", 64'(iq_count), 64'd13);
        check("ready13", 64'(iq_ready), 64'd1);
        drain();

        // Steady state across wrap-around.
        pc = 32'h0000_4000;
        cycle(1'b1, pc, 1'b1, pc + 4, 0, 1'b0);
        pc += 8;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, pc, 1'b1, pc + 4, 2, 1'b0);
            pc += 8;
        end
        drain();

        // Flush at count 6 with concurrent enqueue and dequeue.
        pc = 32'h0000_8000;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, pc, 1'b1, pc + 4, 0, 1'b0);
            pc += 8;
        end
        cycle(1'b1, 32'hF1F1_0000, 1'b1, 32'hF1F1_0004, 1, 1'b1);
        cycle(1'b1, 32'h0000_9000, 1'b0, 32'h0, 0, 1'b0);
        drain();

        // Asynchronous reset mid-operation clears state before any edge.
        cycle(1'b1, 32'h0000_A000, 1'b1, 32'h0000_A004, 0, 1'b0);
        cycle(1'b1, 32'h0000_A008, 1'b0, 32'h0, 0, 1'b0);
        reset = 1'b1;
        #1;
        check("arst_count", 64'(iq_count), 64'd0);
        check("arst_v1", 64'(ds_inst1_valid), 64'd0);
        check("arst_ready", 64'(iq_ready), 64'd1);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0);

`ifdef IQ_BYPASS_EN
        // Bypass: empty queue forwards fetch slots in the same cycle.
        drive(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0204, 1, 1'b0);
        #1;
        check("byp_v1", 64'(ds_inst1_valid), 64'd1);
        check("byp_pc1", 64'(ds_inst1_pc), 64'h200);
        check("byp_pc2", 64'(ds_inst2_pc), 64'h204);
        exp_q.push_back(mk(32'h0000_0204));
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        check_outputs();
        drain();
`endif
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
